// File: rtl/serial_acc_pkg.sv
// Shared types for the bit-serial accumulator: operation codes, FSM states and default word length.
package serial_acc_pkg;

    localparam int WORD_W_DEFAULT = 36;

    typedef enum logic [1:0] {
        OP_HOLD  = 2'b00,
        OP_CLEAR = 2'b01,
        OP_ADD   = 2'b10,
        OP_SUB   = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ARMED = 2'b01,
        ST_RUN   = 2'b10
    } state_e;

endpackage

// File: rtl/serial_adder_bit.sv
// One-bit serial full adder with its carry flop; b can be inverted and the carry preset for the first bit.
module serial_adder_bit (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic first,
    input  logic invert,
    input  logic a,
    input  logic b,
    output logic sum,
    output logic carry_in,
    output logic carry_out
);

    logic carry_q;
    logic b_eff;

    // Subtract presets the carry to 1 at bit 0 (two's complement +1), add presets it to 0.
    assign b_eff     = b ^ invert;
    assign carry_in  = first ? invert : carry_q;
    assign sum       = a ^ b_eff ^ carry_in;
    assign carry_out = (a & b_eff) | (a & carry_in) | (b_eff & carry_in);

    always_ff @(negedge clk) begin
        if (rst) begin
            carry_q <= 1'b0;
        end else if (en) begin
            carry_q <= carry_out;
        end
    end

endmodule

// File: rtl/serial_accumulator.sv
// Bit-serial accumulator: a circulating WORD_W-bit register stepped by one-hot digit pulses on the falling clock edge.
module serial_accumulator
    import serial_acc_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD_W-1:0] digit_pulse,
    input  logic [1:0]        op,
    input  logic              op_valid,
    input  logic              serial_in,
    output logic              acc_serial_out,
    output logic [WORD_W-1:0] acc_word,
    output logic              busy,
    output logic              done,
    output logic              overflow
);

    state_e            state_q, state_d;
    op_e               op_q, op_d;
    logic [WORD_W-1:0] acc_q;
    logic [WORD_W-1:0] acc_next;
    logic              slot_any, slot_first, slot_last;
    logic              proc, first_bit, complete;
    logic              wr_bit;
    logic              sum, carry_in, carry_out;

    assign slot_any   = |digit_pulse;
    assign slot_first = digit_pulse[0];
    assign slot_last  = digit_pulse[WORD_W-1];

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        proc      = 1'b0;
        first_bit = 1'b0;
        complete  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (op_valid && (op != OP_HOLD)) begin
                    op_d    = op_e'(op);
                    state_d = ST_ARMED;
                end
            end
            ST_ARMED: begin
                // Wait for a fresh slot 0; the acceptance edge itself never processes.
                if (slot_first) begin
                    proc      = 1'b1;
                    first_bit = 1'b1;
                    state_d   = ST_RUN;
                end
            end
            ST_RUN: begin
                if (slot_any) begin
                    proc = 1'b1;
                    if (slot_last) begin
                        complete = 1'b1;
                        state_d  = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    serial_adder_bit u_adder (
        .clk       (clk),
        .rst       (rst),
        .en        (proc),
        .first     (first_bit),
        .invert    (op_q == OP_SUB),
        .a         (acc_q[0]),
        .b         (serial_in),
        .sum       (sum),
        .carry_in  (carry_in),
        .carry_out (carry_out)
    );

    always_comb begin
        wr_bit = acc_q[0];
        if (proc) begin
            wr_bit = (op_q == OP_CLEAR) ? 1'b0 : sum;
        end
    end

    assign acc_next       = {wr_bit, acc_q[WORD_W-1:1]};
    assign acc_serial_out = acc_q[0];
    assign busy           = (state_q != ST_IDLE);

    always_ff @(negedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_HOLD;
            acc_q    <= '0;
            acc_word <= '0;
            overflow <= 1'b0;
            done     <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            done    <= complete;
            if (slot_any) begin
                acc_q <= acc_next;
            end
            if (complete) begin
                acc_word <= acc_next;
            end
            // Sign overflow is judged on the top bit: carry into it versus carry out of it.
            if (complete && (op_q == OP_CLEAR)) begin
                overflow <= 1'b0;
            end else if (complete && (carry_in != carry_out)) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: doc/serial_accumulator.md
SERIAL_ACCUMULATOR -- requirements
Module: serial_accumulator

Interface
REQ-001 Parameter: WORD_W, default 36, word length in digit slots; SHALL equal the digit_pulse bus width.
REQ-002 Port: clk  input  1  system clock; all state SHALL update on the falling edge, the same edge as the digit pulse generator.
REQ-003 Port: rst  input  1  reset, synchronous, active-high, sampled on the falling edge of clk.
REQ-004 Port: digit_pulse  input  WORD_W  one-hot digit timing from digit_pulse_generator; digit_pulse[j] high during the clk-high phase before a falling edge marks that edge as slot j.
REQ-005 Port: op  input  2  operation code: 00 hold, 01 clear, 10 add, 11 subtract.
REQ-006 Port: op_valid  input  1  op request strobe.
REQ-007 Port: serial_in  input  1  operand bit j, LSB first, valid at slot j.
REQ-008 Port: acc_serial_out  output  1  accumulator bit j during slot j.
REQ-009 Port: acc_word  output  WORD_W  parallel copy of the accumulator, updated at the end of each operation.
REQ-010 Port: busy  output  1  high from request acceptance until operation completion.
REQ-011 Port: done  output  1  one-clock pulse after slot WORD_W-1 of an operation.
REQ-012 Port: overflow  output  1  sticky two's-complement overflow flag.

Function
REQ-013 The accumulator SHALL be a WORD_W-bit circulating shift register: on every slot it rotates right by one, acc_serial_out is bit 0, and the written bit enters bit WORD_W-1.
REQ-014 A falling edge with no digit_pulse bit set SHALL leave all datapath state unchanged.
REQ-015 The FSM SHALL have three states, IDLE, ARMED and RUN, and SHALL reset to IDLE.
REQ-016 IDLE: op_valid with op != 00 SHALL latch op, set busy, and go to ARMED; op 00 and op_valid while busy SHALL be ignored.
REQ-017 ARMED: the slot-0 edge SHALL process bit 0 and go to RUN; slots 1..WORD_W-1 SHALL only circulate.
REQ-018 RUN: each slot j SHALL process bit j; the slot WORD_W-1 edge SHALL return to IDLE, clear busy, update acc_word, and assert done for exactly the next clock.
REQ-019 Clear SHALL write 0 for every bit and SHALL clear overflow.
REQ-020 Add SHALL write acc_bit XOR serial_in XOR carry; carry SHALL be forced to 0 at bit 0.
REQ-021 Subtract SHALL use inverted serial_in; carry SHALL be forced to 1 at bit 0.
REQ-022 Carry SHALL be discarded after bit WORD_W-1, so results wrap modulo 2^WORD_W.
REQ-023 overflow SHALL set when the carry into bit WORD_W-1 differs from the carry out of it, and SHALL hold until a clear or reset.
REQ-024 A request accepted exactly at slot 0 SHALL wait for the next slot 0 and SHALL NOT process that same edge.

Reset
REQ-025 On rst: acc=0, acc_word=0, carry=0, overflow=0, busy=0, done=0, state=IDLE.
REQ-026 rst mid-operation SHALL abort the operation with no done pulse.
REQ-027 rst SHALL take priority over op_valid and digit_pulse on the same edge.

Structure
REQ-028 The package serial_acc_pkg SHALL hold the op encoding enum, the FSM state enum and the default WORD_W.
REQ-029 The single sub-module serial_adder_bit SHALL hold the carry flop and the sum/carry logic, with an inputs-invert control and a carry-preset control.

Verification
REQ-030 Reset, then add 5 (serial_in pattern 000..0101) -> done once after slot 35; acc_word=5; overflow=0.
REQ-031 With acc=5, subtract 7 -> acc_word=36'hFFFFFFFFE (-2); overflow=0.
REQ-032 With acc=36'h7FFFFFFFF, add 1 -> acc_word=36'h800000000; overflow=1; a following add 0 -> overflow stays 1; clear -> acc_word=0 and overflow=0.
REQ-033 Request accepted at slot 17 -> processing starts at the next slot 0; busy stays high for 36 slots plus the wait; a second op_valid while busy is ignored.
REQ-034 rst asserted at slot 20 of an add -> no done pulse; all outputs 0; a following add 3 gives acc_word=3.
REQ-035 Hold acc=0x123456789 with no ops for 3 minor cycles -> acc_serial_out reproduces bits 0..35 in every cycle; acc_word unchanged.
